// File: rtl/spi_frame_decoder_if.sv
// Byte stream, transmit handshake and register port of spi_frame_decoder.
// master: decoder side; slave: shifter / register bank side.
interface spi_frame_decoder_if #(
  parameter int ADDR_WIDTH = 8
) ();
  logic                  in_data_valid;
  logic [7:0]            in_data;
  logic                  out_data_valid;
  logic [7:0]            out_data;
  logic                  out_data_ready;
  logic                  reg_write;
  logic                  reg_read;
  logic [ADDR_WIDTH-1:0] reg_address;
  logic [7:0]            reg_write_data;
  logic [7:0]            reg_read_data;

  modport master (
    input  in_data_valid, in_data,
    input  out_data_ready, reg_read_data,
    output out_data_valid, out_data,
    output reg_write, reg_read,
    output reg_address, reg_write_data
  );

  modport slave (
    output in_data_valid, in_data,
    output out_data_ready, reg_read_data,
    input  out_data_valid, out_data,
    input  reg_write, reg_read,
    input  reg_address, reg_write_data
  );
endinterface

// File: rtl/spi_frame_decoder.sv
// SPI byte-frame decoder: opcode/address/data frames -> register strobes,
// read data returned over a valid/ready handshake.
// Ports: clock, not_reset (async, active low), frame_idle (CS deasserted),
//   bus (spi_frame_decoder_if.master), overrun (sticky), error_count.
// Option: SPI_FRAME_DECODER_ERROR_COUNT_EN enables the saturating
//   error counter; otherwise error_count is tied to zero.
module spi_frame_decoder #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                clock,
  input  logic                not_reset,
  input  logic                frame_idle,
  spi_frame_decoder_if.master bus,
  output logic                overrun,
  output logic [7:0]          error_count
);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_ADDRESS,
    S_WRITE,
    S_READ,
    S_DISCARD
  } state_t;

  state_t                state;
  logic                  is_read;
  logic                  idle_q;
  logic [ADDR_WIDTH-1:0] addr;

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset) begin
      state              <= S_OPCODE;
      is_read            <= 1'b0;
      idle_q             <= 1'b0;
      addr               <= '0;
      overrun            <= 1'b0;
      bus.reg_write      <= 1'b0;
      bus.reg_read       <= 1'b0;
      bus.reg_address    <= '0;
      bus.reg_write_data <= 8'h00;
      bus.out_data_valid <= 1'b0;
      bus.out_data       <= 8'h00;
    end else begin
      idle_q        <= frame_idle;
      bus.reg_write <= 1'b0;
      bus.reg_read  <= 1'b0;

      if (frame_idle) begin
        state <= S_OPCODE;
      end else if (bus.in_data_valid) begin
        unique case (state)
          S_OPCODE: begin
            unique case (1'b1)
              (bus.in_data == 8'h01): begin
                is_read <= 1'b0;
                state   <= S_ADDRESS;
              end
              (bus.in_data == 8'h02): begin
                is_read <= 1'b1;
                state   <= S_ADDRESS;
              end
              default: state <= S_DISCARD;
            endcase
          end
          S_ADDRESS: begin
            addr            <= bus.in_data[ADDR_WIDTH-1:0];
            bus.reg_address <= bus.in_data[ADDR_WIDTH-1:0];
            bus.reg_read    <= is_read;
            state           <= is_read ? S_READ : S_WRITE;
          end
          S_WRITE: begin
            bus.reg_write      <= 1'b1;
            bus.reg_address    <= addr;
            bus.reg_write_data <= bus.in_data;
            addr               <= addr + 1'b1;
          end
          S_READ: begin
            bus.reg_read    <= 1'b1;
            bus.reg_address <= addr + 1'b1;
            addr            <= addr + 1'b1;
          end
          S_DISCARD: state <= S_DISCARD;
          default:   state <= S_OPCODE;
        endcase
      end

      // Frame start clears the sticky flag; a drop in the
      // same cycle still wins because it is assigned later.
      if (idle_q && !frame_idle)
        overrun <= 1'b0;

      // Bank data is sampled while reg_read is high so the
      // result is offered on the following cycle.
      if (frame_idle) begin
        bus.out_data_valid <= 1'b0;
      end else if (bus.reg_read) begin
        if (bus.out_data_valid && !bus.out_data_ready) begin
          overrun <= 1'b1;
        end else begin
          bus.out_data       <= bus.reg_read_data;
          bus.out_data_valid <= 1'b1;
        end
      end else if (bus.out_data_valid && bus.out_data_ready) begin
        bus.out_data_valid <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_DECODER_ERROR_COUNT_EN
  logic       bad_op;
  logic       drop;
  logic [1:0] inc;
  logic [8:0] sum;
  logic [7:0] err_q;

  assign bad_op = !frame_idle && bus.in_data_valid &&
                  (state == S_OPCODE) &&
                  (bus.in_data != 8'h01) &&
                  (bus.in_data != 8'h02);
  assign drop   = !frame_idle && bus.reg_read &&
                  bus.out_data_valid && !bus.out_data_ready;
  assign inc    = {1'b0, bad_op} + {1'b0, drop};
  assign sum    = {1'b0, err_q} + {7'b0, inc};

  always_ff @(posedge clock or negedge not_reset) begin
    if (!not_reset)
      err_q <= 8'h00;
    else
      err_q <= sum[8] ? 8'hFF : sum[7:0];
  end

  assign error_count = err_q;
`else
  assign error_count = 8'h00;
`endif

endmodule
